twos_complement_serial: RTL and testbench

Parametrised, bit-serial negation unit: accepts a WIDTH-bit word through a valid/ready handshake and processes it LSB-first, one bit per clock. Four modes are supported: pass, one's complement, two's complement, and absolute value. The result and an overflow flag are presented on a second valid/ready handshake. It is the area-lean successor to the combinational 4-bit complementer, for datapaths where a WIDTH-cycle latency is acceptable.

---
 rtl/twos_complement_serial.sv | 135 +++++++++++++
 tb/tb_twos_complement_serial.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_complement_serial.sv
// Bit-serial pass / one's / two's / absolute-value unit, LSB first, one bit per clock.
// Operands and results move over two independent valid/ready handshakes.
module twos_complement_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);
    // Handshake rule: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and the sender holds its payload until the transfer.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       mode_q, mode_d;
    logic             neg_q, neg_d;
    logic             msb_q, msb_d;
    logic             seen_q, seen_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             bit_in;
    logic             bit_out;

    // Serial negation: copy bits up to and including the first 1, invert the rest.
    always_comb begin
        bit_in = src_q[0];
        if (mode_q == 2'b01) begin
            bit_out = ~bit_in;
        end else if (neg_q) begin
            bit_out = seen_q ? ~bit_in : bit_in;
        end else begin
            bit_out = bit_in;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        res_d   = res_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        msb_d   = msb_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    mode_d  = in_mode;
                    neg_d   = (in_mode == 2'b10) || ((in_mode == 2'b11) && in_data[WIDTH-1]);
                    msb_d   = in_data[WIDTH-1];
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                src_d  = src_q >> 1;
                res_d  = {bit_out, res_q[WIDTH-1:1]};
                seen_d = seen_q | (neg_q & bit_in);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Only the minimum value has its sign bit survive negation.
                    ovf_d   = neg_q & msb_q & bit_out;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            res_q   <= '0;
            mode_q  <= 2'b00;
            neg_q   <= 1'b0;
            msb_q   <= 1'b0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            msb_q   <= msb_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign out_data  = res_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_twos_complement_serial.sv
// Bench for twos_complement_serial: directed vector table, backpressure and reset
// sequences, random operands at WIDTH=8 and an exhaustive back-to-back sweep at WIDTH=4.
module tb_twos_complement_serial;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT, WIDTH=8 ----------------
    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, out_ovf8, busy8;
    logic [7:0] in_data8 = 8'h00, out_data8;
    logic [1:0] in_mode8 = 2'b00;

    twos_complement_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_ovf(out_ovf8), .busy(busy8)
    );

    // ---------------- DUT, WIDTH=4 ----------------
    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_ovf4, busy4;
    logic [3:0] in_data4 = 4'h0, out_data4;
    logic [1:0] in_mode4 = 2'b00;

    twos_complement_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_ovf(out_ovf4), .busy(busy4)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp4_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: interpret the operand as a signed w-bit integer and do plain arithmetic.
    function automatic logic [8:0] ref_op(input logic [1:0] m, input logic [7:0] d, input int w);
        int  mask;
        int  u;
        int  v;
        int  n;
        int  res;
        logic ovf;
        mask = (1 << w) - 1;
        u    = int'(d) & mask;
        v    = (u >= (1 << (w - 1))) ? u - (1 << w) : u;
        n    = 0;
        res  = u;
        ovf  = 1'b0;
        case (m)
            2'd0: res = u;
            2'd1: res = ~u & mask;
            2'd2: n = -v;
            default: n = (v < 0) ? -v : v;
        endcase
        if (m >= 2'd2) begin
            res = n & mask;
            ovf = (n > (1 << (w - 1)) - 1);
        end
        return {ovf, 8'(res)};
    endfunction

    // ---------------- driver tasks (WIDTH=8) ----------------
    task automatic wait_ready8();
        int guard = 0;
        while (!in_ready8 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", int'(in_ready8), 1);
    endtask

    task automatic run8(input logic [1:0] mode, input logic [7:0] data,
                        output logic [7:0] res, output logic ovf, output int lat);
        wait_ready8();
        in_valid8 = 1'b1;
        in_mode8  = mode;
        in_data8  = data;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        in_data8  = 8'($urandom);
        in_mode8  = 2'($urandom);
        check("in_ready_after_accept", int'(in_ready8), 0);
        check("busy_after_accept", int'(busy8), 1);
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_data8;
        ovf = out_ovf8;
    endtask

    task automatic take8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("out_valid_after_take", int'(out_valid8), 0);
        check("in_ready_after_take", int'(in_ready8), 1);
    endtask

    // ---------------- WIDTH=4 result monitor ----------------
    bit         mon4_en   = 1'b0;
    int         last_rise = -1;
    int         n_res4    = 0;
    logic [8:0] e4;

    // One idle accept cycle, WIDTH shift cycles, one handshake cycle.
    localparam int SPACING4 = 4 + 2;

    always @(negedge clk) begin
        if (mon4_en && out_valid4) begin
            if (exp4_q.size() == 0) begin
                check("w4_unexpected_result", int'(out_valid4), 0);
            end else begin
                e4 = exp4_q.pop_front();
                check("w4_data", int'(out_data4), int'(e4[3:0]));
                check("w4_ovf", int'(out_ovf4), int'(e4[8]));
            end
            if (last_rise >= 0) check("w4_spacing", cyc - last_rise, SPACING4);
            last_rise = cyc;
            n_res4++;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [7:0] res;
        logic       ovf;
        int         lat;
        logic [8:0] e;
        int         guard;

        vecs[0] = '{2'b10, 8'h05, 8'hFB, 1'b0};
        vecs[1] = '{2'b10, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{2'b10, 8'h80, 8'h80, 1'b1};
        vecs[3] = '{2'b11, 8'h80, 8'h80, 1'b1};
        vecs[4] = '{2'b01, 8'h80, 8'h7F, 1'b0};
        vecs[5] = '{2'b11, 8'hF6, 8'h0A, 1'b0};
        vecs[6] = '{2'b11, 8'h0A, 8'h0A, 1'b0};
        vecs[7] = '{2'b01, 8'h3C, 8'hC3, 1'b0};
        vecs[8] = '{2'b00, 8'hA5, 8'hA5, 1'b0};

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid8), 0);
        check("rst_out_data", int'(out_data8), 0);
        check("rst_out_ovf", int'(out_ovf8), 0);
        check("rst_busy", int'(busy8), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(in_ready8), 1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].mode, vecs[i].data, res, ovf, lat);
            check($sformatf("vec%0d_data", i), int'(res), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_latency", i), lat, 8);
            take8();
        end

        // Backpressure, with input noise during SHIFT
        wait_ready8();
        in_valid8 = 1'b1;
        in_mode8  = 2'b10;
        in_data8  = 8'h05;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in_valid8 = 1'($urandom_range(0, 1));
            in_data8  = 8'($urandom);
            in_mode8  = 2'($urandom);
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        guard = 0;
        while (!out_valid8 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_out_valid", int'(out_valid8), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_data", int'(out_data8), 8'hFB);
            check("bp_hold_ovf", int'(out_ovf8), 0);
            check("bp_hold_valid", int'(out_valid8), 1);
            check("bp_in_ready", int'(in_ready8), 0);
        end
        take8();

        // Reset on the third SHIFT cycle
        wait_ready8();
        in_valid8 = 1'b1;
        in_mode8  = 2'b10;
        in_data8  = 8'h33;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", int'(in_ready8), 1);
        check("midrst_out_valid", int'(out_valid8), 0);
        check("midrst_out_data", int'(out_data8), 0);
        check("midrst_busy", int'(busy8), 0);
        run8(2'b10, 8'h01, res, ovf, lat);
        check("after_rst_data", int'(res), 8'hFF);
        check("after_rst_ovf", int'(ovf), 0);
        take8();

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            logic [7:0] d;
            m = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            exp_q.push_back(ref_op(m, d, 8));
            run8(m, d, res, ovf, lat);
            e = exp_q.pop_front();
            check("rand_data", int'(res), int'(e[7:0]));
            check("rand_ovf", int'(ovf), int'(e[8]));
            check("rand_latency", lat, 8);
            take8();
        end

        // WIDTH=4: every operand in every mode, back-to-back, out_ready tied high
        mon4_en = 1'b1;
        for (int m = 0; m < 4; m++) begin
            for (int d = 0; d < 16; d++) begin
                in_mode4  = 2'(m);
                in_data4  = 4'(d);
                in_valid4 = 1'b1;
                guard = 0;
                while (!in_ready4 && guard < 50) begin
                    @(posedge clk); #1;
                    guard++;
                end
                if (guard >= 50) check("w4_accept_wait", int'(in_ready4), 1);
                @(posedge clk); #1;
                exp4_q.push_back(ref_op(2'(m), {4'h0, 4'(d)}, 4));
            end
        end
        in_valid4 = 1'b0;
        guard = 0;
        while (n_res4 < 64 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("w4_result_count", n_res4, 64);
        check("w4_queue_empty", exp4_q.size(), 0);
        mon4_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
